// File: rtl/keycode_event_scheduler.sv
// rtl/keycode_event_scheduler.sv - HID keycode word to ordered press/release event stream
//
// Purpose:
//   Compares the current keycode word against the last committed word one slot
//   per cycle. It queues a release for every code that disappeared and a press
//   for every code that appeared. The events go into a show-ahead FIFO that a
//   valid/ready consumer drains. It also keeps a held mask for W/A/S/D.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   keycode_in   NUM_SLOTS packed keycodes, slot i = keycode_in[KEY_W*i +: KEY_W]
//   event_ready  consumer accepts the head event this cycle
//   event_valid  FIFO non-empty, head event presented
//   event_code   head event keycode (0 when empty)
//   event_press  1 = press, 0 = release (0 when empty)
//   held_mask    committed held keys: [0] W, [1] A, [2] S, [3] D
//   busy         scan in progress (FSM not idle)

module keycode_event_scheduler #(
  parameter int NUM_SLOTS  = 3,
  parameter int KEY_W      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SLOTS*KEY_W-1:0] keycode_in,
  input  logic                       event_ready,
  output logic                       event_valid,
  output logic [KEY_W-1:0]           event_code,
  output logic                       event_press,
  output logic [3:0]                 held_mask,
  output logic                       busy
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLOTS - 1);

  localparam logic [KEY_W-1:0] CODE_W        = KEY_W'(8'h1A);
  localparam logic [KEY_W-1:0] CODE_A        = KEY_W'(8'h04);
  localparam logic [KEY_W-1:0] CODE_S        = KEY_W'(8'h16);
  localparam logic [KEY_W-1:0] CODE_D        = KEY_W'(8'h07);
  localparam logic [KEY_W-1:0] CODE_ROLLOVER = KEY_W'(8'h01);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REL,
    ST_PRS,
    ST_COMMIT
  } state_t;

  state_t state, next_state;
  logic [IW-1:0] idx, next_idx;

  logic [NUM_SLOTS*KEY_W-1:0] prev, cur;
  logic [KEY_W-1:0] in_s   [NUM_SLOTS];
  logic [KEY_W-1:0] prev_s [NUM_SLOTS];
  logic [KEY_W-1:0] cur_s  [NUM_SLOTS];

  logic rollover, rel_hit, prs_hit;
  logic capture, commit, push_req, push, pop, stall;
  logic [KEY_W:0] push_data;
  logic [3:0] held_next;

  // FIFO storage: entry = {code, press}
  logic [KEY_W:0] mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           empty, full;
  logic [KEY_W:0] head;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      in_s[i]   = keycode_in[i*KEY_W +: KEY_W];
      prev_s[i] = prev[i*KEY_W +: KEY_W];
      cur_s[i]  = cur[i*KEY_W +: KEY_W];
    end
  end

  // Slot comparisons for the slot currently selected by idx
  always_comb begin
    logic in_cur, in_prev, dup;
    rollover = 1'b0;
    in_cur   = 1'b0;
    in_prev  = 1'b0;
    dup      = 1'b0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      if (in_s[j] == CODE_ROLLOVER) rollover = 1'b1;
      if (cur_s[j] == prev_s[idx]) in_cur = 1'b1;
      if (prev_s[j] == cur_s[idx]) in_prev = 1'b1;
      // a code repeated in several slots is reported only at its lowest slot
      if ((j < int'(idx)) && (cur_s[j] == cur_s[idx])) dup = 1'b1;
    end
    rel_hit = (prev_s[idx] != '0) && !in_cur;
    prs_hit = (cur_s[idx] != '0) && !in_prev && !dup;
  end

  always_comb begin
    held_next = 4'b0000;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      if (cur_s[j] == CODE_W) held_next[0] = 1'b1;
      if (cur_s[j] == CODE_A) held_next[1] = 1'b1;
      if (cur_s[j] == CODE_S) held_next[2] = 1'b1;
      if (cur_s[j] == CODE_D) held_next[3] = 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
  assign pop   = !empty && event_ready;

  // Next-state logic; a step that needs to push into a full FIFO with no
  // simultaneous pop holds in place so no event is lost.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    capture    = 1'b0;
    commit     = 1'b0;
    push_req   = 1'b0;
    push_data  = {prev_s[idx], 1'b0};
    case (state)
      ST_IDLE: begin
        if (!rollover && (keycode_in != prev)) begin
          capture    = 1'b1;
          next_state = ST_REL;
          next_idx   = '0;
        end
      end
      ST_REL: begin
        push_req  = rel_hit;
        push_data = {prev_s[idx], 1'b0};
      end
      ST_PRS: begin
        push_req  = prs_hit;
        push_data = {cur_s[idx], 1'b1};
      end
      ST_COMMIT: begin
        commit     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase

    stall = push_req && full && !pop;
    push  = push_req && !stall;

    if (((state == ST_REL) || (state == ST_PRS)) && !stall) begin
      if (idx == LAST_IDX) begin
        next_idx   = '0;
        next_state = (state == ST_REL) ? ST_PRS : ST_COMMIT;
      end else begin
        next_idx = idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      prev      <= '0;
      cur       <= '0;
      held_mask <= 4'b0000;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
      if (capture) cur <= keycode_in;
      if (commit) begin
        prev      <= cur;
        held_mask <= held_next;
      end
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: outputs are gated by the empty flag
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign event_valid = !empty;
  assign event_code  = empty ? '0 : head[KEY_W:1];
  assign event_press = !empty && head[0];
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_keycode_event_scheduler.sv
// tb/tb_keycode_event_scheduler.sv - directed bench for keycode_event_scheduler

module tb_keycode_event_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] keycode_in;
  logic        event_ready;
  logic        event_valid;
  logic [7:0]  event_code;
  logic        event_press;
  logic [3:0]  held_mask;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keycode_event_scheduler #(
    .NUM_SLOTS (3),
    .KEY_W     (8),
    .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .keycode_in (keycode_in),
    .event_ready(event_ready),
    .event_valid(event_valid),
    .event_code (event_code),
    .event_press(event_press),
    .held_mask  (held_mask),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the head event, check it, then let it pop on the next edge
  task automatic wait_event(input string tag, input logic [7:0] code, input logic press);
    int n = 0;
    while (!event_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'b0, event_valid}, 32'd1);
    chk({tag, "_code"},  {24'b0, event_code},  {24'b0, code});
    chk({tag, "_press"}, {31'b0, event_press}, {31'b0, press});
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    keycode_in  = 24'h000000;
    event_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", {31'b0, event_valid}, 32'd0);
    chk("rst_code",  {24'b0, event_code},  32'd0);
    chk("rst_press", {31'b0, event_press}, 32'd0);
    chk("rst_held",  {28'b0, held_mask},   32'd0);
    chk("rst_busy",  {31'b0, busy},        32'd0);

    // 1: single press, exact latency
    keycode_in = 24'h00001A;
    tick();                               // capture edge E
    chk("t1_busy_e", {31'b0, busy}, 32'd1);
    repeat (3) tick();                    // E+3: no push yet
    chk("t1_valid_e3", {31'b0, event_valid}, 32'd0);
    tick();                               // E+4: PRS(0) pushed
    chk("t1_valid_e4", {31'b0, event_valid}, 32'd1);
    chk("t1_code_e4",  {24'b0, event_code},  32'h1A);
    chk("t1_press_e4", {31'b0, event_press}, 32'd1);
    chk("t1_held_e4",  {28'b0, held_mask},   32'd0);
    repeat (2) tick();                    // E+6: COMMIT
    chk("t1_busy_e6",  {31'b0, busy},        32'd1);
    chk("t1_held_e6",  {28'b0, held_mask},   32'd0);
    chk("t1_valid_e6", {31'b0, event_valid}, 32'd0);
    tick();                               // E+7: IDLE
    chk("t1_busy_e7",  {31'b0, busy},      32'd0);
    chk("t1_held_e7",  {28'b0, held_mask}, 32'h1);

    // 2: add D, then drop W
    keycode_in = 24'h00071A;
    tick();
    wait_event("t2a", 8'h07, 1'b1);
    wait_idle("t2a");
    chk("t2a_held", {28'b0, held_mask}, 32'h9);
    keycode_in = 24'h000700;
    tick();
    wait_event("t2b", 8'h1A, 1'b0);
    wait_idle("t2b");
    chk("t2b_held",  {28'b0, held_mask},   32'h8);
    chk("t2b_empty", {31'b0, event_valid}, 32'd0);

    // 3: clear, then duplicated code reported once in slot order
    keycode_in = 24'h000000;
    tick();
    wait_event("t3a", 8'h07, 1'b0);
    wait_idle("t3a");
    chk("t3a_held", {28'b0, held_mask}, 32'h0);
    keycode_in = 24'h1A1A04;
    tick();
    wait_event("t3b", 8'h04, 1'b1);
    wait_event("t3c", 8'h1A, 1'b1);
    wait_idle("t3c");
    chk("t3_nodup", {31'b0, event_valid}, 32'd0);
    chk("t3_held",  {28'b0, held_mask},   32'h3);

    // 4: back to W only, then rollover word is ignored
    keycode_in = 24'h00001A;
    tick();
    wait_event("t4a", 8'h04, 1'b0);
    wait_idle("t4a");
    chk("t4a_held", {28'b0, held_mask}, 32'h1);
    keycode_in = 24'h010101;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_busy",  {31'b0, busy},        32'd0);
      chk("t4_valid", {31'b0, event_valid}, 32'd0);
    end
    chk("t4_held", {28'b0, held_mask}, 32'h1);

    // 5: FIFO full stall with consumer held off
    keycode_in = 24'h000000;
    tick();
    wait_event("t5a", 8'h1A, 1'b0);
    wait_idle("t5a");
    event_ready = 1'b0;
    keycode_in  = 24'h16071A;
    repeat (10) tick();
    chk("t5_stall_busy",  {31'b0, busy},        32'd1);
    chk("t5_stall_valid", {31'b0, event_valid}, 32'd1);
    chk("t5_stall_code",  {24'b0, event_code},  32'h1A);
    chk("t5_stall_held",  {28'b0, held_mask},   32'h0);
    event_ready = 1'b1;
    wait_event("t5b", 8'h1A, 1'b1);
    wait_event("t5c", 8'h07, 1'b1);
    wait_event("t5d", 8'h16, 1'b1);
    wait_idle("t5d");
    chk("t5_empty", {31'b0, event_valid}, 32'd0);
    chk("t5_held",  {28'b0, held_mask},   32'hD);

    // 6: reset mid-scan discards queue, held key re-reported as press
    keycode_in = 24'h000000;
    tick();
    wait_event("t6a", 8'h1A, 1'b0);
    wait_event("t6b", 8'h07, 1'b0);
    wait_event("t6c", 8'h16, 1'b0);
    wait_idle("t6c");
    keycode_in = 24'h00001A;
    tick();                               // capture edge E
    repeat (4) tick();                    // E+4: in PRS(1), 0x1A queued
    event_ready = 1'b0;
    chk("t6_pre_busy",  {31'b0, busy},        32'd1);
    chk("t6_pre_valid", {31'b0, event_valid}, 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", {31'b0, event_valid}, 32'd0);
    chk("t6_rst_held",  {28'b0, held_mask},   32'h0);
    chk("t6_rst_busy",  {31'b0, busy},        32'd0);
    reset       = 1'b0;
    event_ready = 1'b1;
    tick();
    wait_event("t6d", 8'h1A, 1'b1);
    wait_idle("t6d");
    chk("t6_held",  {28'b0, held_mask},   32'h1);
    chk("t6_empty", {31'b0, event_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
